// File: rtl/asynch_counter.sv
// Synchronous ripple-enable binary up-counter: a chain of T flops sharing clk,
// each stage enabled by the AND of T and every lower stage.

module asynch_counter_tff (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qb
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = state_q;
        if (rst) begin
            state_d = 1'b0;
        end else if (t) begin
            state_d = ~state_q;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign q  = state_q;
    assign qb = ~state_q;

endmodule

module asynch_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             T,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    // t_chain[i] = T & q[0] & ... & q[i-1], built as a ripple AND chain
    logic [WIDTH-1:0] t_chain;

    assign t_chain[0] = T;

    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign t_chain[i] = t_chain[i-1] & q[i-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        asynch_counter_tff u_tff (
            .clk (clk),
            .rst (rst),
            .t   (t_chain[i]),
            .q   (q[i]),
            .qb  (qb[i])
        );
    end

    // Top stage enabled and already set means every bit is one with T high
    assign tc = t_chain[WIDTH-1] & q[WIDTH-1];

endmodule

// File: tb/tb_asynch_counter.sv
// Self-checking bench for asynch_counter at WIDTH 4, 1 and 8, driven in lockstep
// against an arithmetic modulo-2^WIDTH reference.

module tb_asynch_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       T   = 1'b0;

    logic [3:0] q4, qb4;
    logic [0:0] q1, qb1;
    logic [7:0] q8, qb8;
    logic       tc4, tc1, tc8;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned m4 = 0, m1 = 0, m8 = 0;
    bit          reset_seen = 1'b0;

    always #5 clk = ~clk;

    asynch_counter #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .T(T), .q(q4), .qb(qb4), .tc(tc4)
    );
    asynch_counter #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .T(T), .q(q1), .qb(qb1), .tc(tc1)
    );
    asynch_counter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .T(T), .q(q8), .qb(qb8), .tc(tc8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned advance(input int unsigned cur, input int unsigned modulus,
                                            input logic r, input logic t);
        if (r) return 0;
        if (t) return (cur + 1) % modulus;
        return cur;
    endfunction

    // Drive at negedge, check tc before the edge, then q/qb just after it.
    task automatic step(input logic r, input logic t);
        @(negedge clk);
        rst = r;
        T   = t;
        #1;
        if (reset_seen) begin
            check("tc_w4", {31'd0, tc4}, {31'd0, (t && m4 == 15)});
            check("tc_w1", {31'd0, tc1}, {31'd0, (t && m1 == 1)});
            check("tc_w8", {31'd0, tc8}, {31'd0, (t && m8 == 255)});
        end
        @(posedge clk);
        #1;
        m4 = advance(m4, 16, r, t);
        m1 = advance(m1, 2, r, t);
        m8 = advance(m8, 256, r, t);
        if (r) reset_seen = 1'b1;
        if (reset_seen) begin
            check("q_w4",  {28'd0, q4},  m4);
            check("qb_w4", {28'd0, qb4}, (~m4) & 32'hF);
            check("q_w1",  {31'd0, q1},  m1);
            check("qb_w1", {31'd0, qb1}, (~m1) & 32'h1);
            check("q_w8",  {24'd0, q8},  m8);
            check("qb_w8", {24'd0, qb8}, (~m8) & 32'hFF);
        end
    endtask

    initial begin
        step(1'b1, 1'b0);                         // reset with T=0
        check("reset_q4", {28'd0, q4}, 32'h0);
        check("reset_qb4", {28'd0, qb4}, 32'hF);
        repeat (2) step(1'b0, 1'b0);              // hold at 0
        repeat (3) step(1'b0, 1'b1);              // count to 3
        step(1'b1, 1'b1);                         // mid-count reset wins over T
        check("midrst_q4", {28'd0, q4}, 32'h0);
        step(1'b0, 1'b1);
        check("resume_q4", {28'd0, q4}, 32'h1);
        repeat (5) step(1'b0, 1'b1);              // to 6
        repeat (3) step(1'b0, 1'b0);              // hold 6
        check("hold_q4", {28'd0, q4}, 32'h6);
        step(1'b0, 1'b1);                         // 7
        repeat (8) step(1'b0, 1'b1);              // to F
        check("full_q4", {28'd0, q4}, 32'hF);
        step(1'b0, 1'b0);                         // tc low with T=0, q holds F
        step(1'b0, 1'b1);                         // tc high, wrap to 0
        check("wrap_q4", {28'd0, q4}, 32'h0);
        repeat (9) step(1'b0, 1'b1);              // to 9
        step(1'b1, 1'b1);                         // reset priority at 9
        check("prio_q4", {28'd0, q4}, 32'h0);
        repeat (260) step(1'b0, 1'b1);            // wide instance wraps FF -> 00
        check("wrap_q8", {24'd0, q8}, 32'd4);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
